ram_param: RTL and testbench

Parametrised single-port synchronous RAM, the successor to the fixed 512×16 RAM. It adds a power-on and on-demand hardware clear sweep, a ready/busy handshake, and a registered read port with a one-cycle `data_valid` strobe. It sits between the CPU datapath and data memory, and replaces fixed-size RAM instances wherever a known memory state after reset is required.

---
 rtl/ram_param_pkg.sv | 12 +
 rtl/ram_param_core.sv | 23 ++
 rtl/ram_param.sv | 110 +++++++++++
 tb/tb_ram_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_param_pkg.sv
// Shared types and default sizes for the parametrised RAM with clear sweep.
package ram_param_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram_param_core.sv
// Plain single-port array: synchronous write, combinational read, no reset.
module ram_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/ram_param.sv
// Single-port RAM with hardware clear sweep, ready/busy handshake and registered read port.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int unsigned          DATA_W    = DEF_DATA_W,
  parameter int unsigned          ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_req,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               core_we;
  logic [ADDR_W-1:0]  core_addr;
  logic [DATA_W-1:0]  core_din;
  logic [DATA_W-1:0]  core_dout;

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .addr (core_addr),
    .din  (core_din),
    .dout (core_dout)
  );

  // Next state, write-port mux (sweep vs. user) and read register update.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    core_we      = 1'b0;
    core_addr    = address;
    core_din     = data_in;

    unique case (state_q)
      ST_CLEAR: begin
        core_we    = 1'b1;
        core_addr  = clr_addr_q[ADDR_W-1:0];
        core_din   = CLEAR_VAL;
        clr_addr_d = CNT_W'(clr_addr_q + CNT_W'(1));
        // Carry into the extra bit marks the last word just written.
        if (clr_addr_d[ADDR_W]) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          if (write_enable) begin
            core_we = 1'b1;
          end else begin
            data_out_d   = core_dout;
            data_valid_d = 1'b1;
          end
        end
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_ram_param.sv
// Scoreboard bench for ram_param: memory model plus expected-read queue checked by a monitor.
module tb_ram_param;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          clear_req;
  logic          ready;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;

  ram_param #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .clear_req    (clear_req),
    .ready        (ready),
    .busy         (busy),
    .data_out     (data_out),
    .data_valid   (data_valid)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (mem_m[i]) mem_m[i] = '0;
  endtask

  // Monitor: every data_valid strobe must match the oldest outstanding read.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: unexpected data_valid with data_out=0x%0h (t=%0t)", data_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", 32'(data_out), 32'(mon_exp));
      end
    end
  end

  // Issue one access at the first negedge where ready is seen high.
  task automatic access(input bit we_i, input int a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      req = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    req          = 1'b1;
    write_enable = we_i;
    address      = AW'(a);
    data_in      = d;
    if (we_i) mem_m[a] = d;
    else      exp_q.push_back(mem_m[a]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req          = 1'b0;
      write_enable = 1'b0;
      clear_req    = 1'b0;
    end
  endtask

  // Count edges until ready rises; optionally require data_out to hold and data_valid to stay low.
  task automatic wait_ready(output int n, input bit chk_hold, input logic [DW-1:0] hold);
    bit bad = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (chk_hold && (data_out !== hold || data_valid !== 1'b0)) bad = 1'b1;
      if (ready) break;
    end
    if (chk_hold) check("hold_during_sweep", 32'(bad), 32'd0);
  endtask

  int n_cyc;

  initial begin
    rst_n = 1'b0; req = 1'b0; write_enable = 1'b0; address = '0;
    data_in = '0; clear_req = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);

    // Power-on sweep length, then corner read.
    rst_n = 1'b1;
    wait_ready(n_cyc, 1'b0, '0);
    check("por_sweep_len", 32'(n_cyc), 32'd512);
    access(1'b0, 9'h1FF, '0);
    idle(2);

    // Back-to-back reads of distinct locations.
    access(1'b1, 9'h001, 16'hAAAA);
    access(1'b1, 9'h1FF, 16'h5555);
    access(1'b0, 9'h1FF, '0);
    access(1'b0, 9'h001, '0);
    @(posedge clk); #1;
    check("b2b_valid_2nd", 32'(data_valid), 32'd1);
    check("b2b_data_2nd", 32'(data_out), 32'hAAAA);
    idle(2);

    // Randomised traffic, biased to a small address window to get hits.
    for (int i = 0; i < 400; i++) begin
      int r, a;
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                      : int'($urandom_range(0, 15));
      if (r < 2)      idle(1);
      else if (r < 6) access(1'b1, a, DW'($urandom));
      else            access(1'b0, a, '0);
    end
    idle(3);

    // Write-then-read same address, then data_out holds.
    access(1'b1, 0, 16'h1234);
    access(1'b0, 0, '0);
    @(negedge clk);
    req = 1'b0; write_enable = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_out", 32'(data_out), 32'h1234);
      check("hold_valid", 32'(data_valid), 32'd0);
    end

    // clear_req on the same edge as a write; requests during the sweep are dropped.
    access(1'b1, 7, 16'h0007);
    clear_req = 1'b1;
    model_clear();
    @(negedge clk);
    req = 1'b0; clear_req = 1'b0;
    check("clr_busy_next", 32'(busy), 32'd1);
    check("clr_ready_next", 32'(ready), 32'd0);
    fork
      wait_ready(n_cyc, 1'b1, 16'h1234);
      begin
        repeat (20) @(negedge clk);
        check("drop_busy", 32'(busy), 32'd1);
        req = 1'b1; write_enable = 1'b1; address = 9'd5; data_in = 16'hBEEF;
        repeat (4) @(negedge clk);
        req = 1'b0; write_enable = 1'b0;
      end
    join
    check("clr_sweep_len", 32'(n_cyc), 32'd512);
    access(1'b0, 7, '0);
    access(1'b0, 5, '0);
    idle(2);

    // Reset in the middle of a sweep.
    access(1'b1, 9, 16'h00AB);
    access(1'b0, 9, '0);
    idle(2);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("pre_rst_hold", 32'(data_out), 32'h00AB);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_data_valid", 32'(data_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_clear();
    exp_q.delete();
    rst_n = 1'b1;
    wait_ready(n_cyc, 1'b0, '0);
    check("midrst_sweep_len", 32'(n_cyc), 32'd512);
    access(1'b0, 9, '0);
    access(1'b0, 9'h1FF, '0);
    idle(3);

    check("reads_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
